// File: rtl/fp_to_int_converter_if.sv
// Handshake bundle between the FP datapath and fp_to_int_converter.
// The master offers operands and accepts results; the slave is the converter.
interface fp_to_int_converter_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_invalid;
  logic        out_inexact;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_invalid, out_inexact
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_invalid, out_inexact
  );
endinterface

// File: rtl/fp_to_int_converter.sv
// Iterative IEEE 754 single -> signed int32 converter, one conversion in flight.
// Define FP2INT_ROUND_NEAREST_EN for round-to-nearest-even; default truncates toward zero.
module fp_to_int_converter #(
  parameter int SHIFT_STEP = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp_to_int_converter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_SHIFT,
    S_ROUND,
    S_DONE
  } state_t;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);
`ifdef FP2INT_ROUND_NEAREST_EN
  localparam logic [7:0] EXP_MIN = 8'd126;
`else
  localparam logic [7:0] EXP_MIN = 8'd127;
`endif

  state_t      state_q, state_d;
  logic [31:0] op_q, op_d;
  logic [31:0] mag_q, mag_d;
  logic        guard_q, guard_d;
  logic        sticky_q, sticky_d;
  logic        left_q, left_d;
  logic [4:0]  rem_q, rem_d;
  logic [31:0] res_q, res_d;
  logic        inval_q, inval_d;
  logic        inex_q, inex_d;

  logic        sign;
  logic [7:0]  expo;
  logic [22:0] frac;
  logic [4:0]  amt;
  logic [31:0] rmag;

  assign sign = op_q[31];
  assign expo = op_q[30:23];
  assign frac = op_q[22:0];

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.out_data    = res_q;
  assign bus.out_invalid = inval_q;
  assign bus.out_inexact = inex_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mag_d    = mag_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    left_d   = left_q;
    rem_d    = rem_q;
    res_d    = res_q;
    inval_d  = inval_q;
    inex_d   = inex_q;
    amt      = (rem_q > STEP) ? STEP : rem_q;
    rmag     = mag_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.in_data;
          state_d = S_UNPACK;
        end
      end

      S_UNPACK: begin
        inval_d = 1'b0;
        inex_d  = 1'b0;
        res_d   = 32'd0;
        state_d = S_DONE;
        if (expo == 8'd0) begin
          inex_d = |frac;
        end else if (expo == 8'd255) begin
          inval_d = 1'b1;
          res_d   = (sign && frac == 23'd0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (expo >= 8'd158) begin
          // -2^31 is the only representable value at this magnitude.
          if (sign && expo == 8'd158 && frac == 23'd0) begin
            res_d = 32'h8000_0000;
          end else begin
            inval_d = 1'b1;
            res_d   = sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
          end
        end else if (expo < EXP_MIN) begin
          inex_d = 1'b1;
        end else begin
          mag_d    = {8'd0, 1'b1, frac};
          guard_d  = 1'b0;
          sticky_d = 1'b0;
          if (expo < 8'd150) begin
            left_d = 1'b0;
            rem_d  = 5'(8'd150 - expo);
          end else begin
            left_d = 1'b1;
            rem_d  = 5'(expo - 8'd150);
          end
          state_d = (rem_d == 5'd0) ? S_ROUND : S_SHIFT;
        end
      end

      S_SHIFT: begin
        // Bit-serial unroll keeps guard separate and folds older guards into sticky.
        for (int i = 0; i < SHIFT_STEP; i++) begin
          if (5'(i) < amt) begin
            if (left_q) begin
              mag_d = {mag_d[30:0], 1'b0};
            end else begin
              sticky_d = sticky_d | guard_d;
              guard_d  = mag_d[0];
              mag_d    = {1'b0, mag_d[31:1]};
            end
          end
        end
        rem_d = rem_q - amt;
        if (rem_d == 5'd0) begin
          state_d = S_ROUND;
        end
      end

      S_ROUND: begin
`ifdef FP2INT_ROUND_NEAREST_EN
        if (guard_q && (sticky_q || mag_q[0])) begin
          rmag = mag_q + 32'd1;
        end
`endif
        res_d   = sign ? (32'd0 - rmag) : rmag;
        inval_d = 1'b0;
        inex_d  = guard_q | sticky_q;
        state_d = S_DONE;
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= 32'd0;
      mag_q    <= 32'd0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      left_q   <= 1'b0;
      rem_q    <= 5'd0;
      res_q    <= 32'd0;
      inval_q  <= 1'b0;
      inex_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mag_q    <= mag_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      left_q   <= left_d;
      rem_q    <= rem_d;
      res_q    <= res_d;
      inval_q  <= inval_d;
      inex_q   <= inex_d;
    end
  end

endmodule
